// File: rtl/regfile_wr_arb_if.sv
// Writeback request bundle between functional-unit requesters and the
// register-file write-port arbiter.
// Ports (signals):
//   req_valid  per-requester valid
//   req_addr   per-requester destination register
//   req_data   per-requester write data
//   req_ready  per-requester grant from the arbiter
// Modports: master = requester side, slave = arbiter side.
interface regfile_wr_arb_if #(
    parameter int N_REQ       = 4,
    parameter int ENTRY_WIDTH = 32,
    parameter int PTR_WIDTH   = 5
);
    logic [N_REQ-1:0]                  req_valid;
    logic [N_REQ-1:0][PTR_WIDTH-1:0]   req_addr;
    logic [N_REQ-1:0][ENTRY_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]                  req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wr_arb.sv
// Round-robin write-port arbiter for the register file: grants up to
// N_WRITE_PORTS non-conflicting writebacks per cycle, registered outputs.
// Ports:
//   clk      clock, rising edge
//   rst_aH   asynchronous active-high reset
//   hold     suppresses all grants this cycle
//   req      request bundle (slave modport): valid/addr/data in, ready out
//   wr_en    registered write enables, one per write port
//   wr_addr  registered write addresses
//   wr_data  registered write data
module regfile_wr_arb #(
    parameter int N_REQ          = 4,
    parameter int N_WRITE_PORTS  = 2,
    parameter int ENTRY_WIDTH    = 32,
    parameter int N_ENTRIES      = 32,
    parameter bit DROP_ADDR0     = 1'b1,
    localparam int PTR_WIDTH     = $clog2(N_ENTRIES)
) (
    input  logic                                    clk,
    input  logic                                    rst_aH,
    input  logic                                    hold,
    regfile_wr_arb_if.slave                         req,
    output logic [N_WRITE_PORTS-1:0]                wr_en,
    output logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0] wr_addr,
    output logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data
);

    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [RR_W-1:0] rr_ptr;
    logic [RR_W-1:0] first_idx;
    logic [RR_W-1:0] nxt_ptr;
    logic            any_grant;
    logic [N_REQ-1:0] grant;

    logic [N_WRITE_PORTS-1:0]                  port_en;
    logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]   port_addr;
    logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] port_data;

    // Scan from rr_ptr; port-consuming grants fill ports in scan order.
    always_comb begin
        int              pos;
        int              n_used;
        logic [RR_W-1:0] idx;
        logic [PTR_WIDTH-1:0] addr;
        logic            take;
        logic            clash;

        grant     = '0;
        port_en   = '0;
        port_addr = '0;
        port_data = '0;
        any_grant = 1'b0;
        first_idx = '0;
        n_used    = 0;
        pos       = 0;
        idx       = '0;
        addr      = '0;
        take      = 1'b0;
        clash     = 1'b0;

        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            idx   = RR_W'(pos);
            addr  = req.req_addr[idx];
            take  = 1'b0;
            clash = 1'b0;
            if (!hold && !rst_aH && req.req_valid[idx]) begin
                if (DROP_ADDR0 && addr == '0) begin
                    // Register 0 writes are swallowed: no port, no conflict.
                    take = 1'b1;
                end else if (n_used < N_WRITE_PORTS) begin
                    for (int p = 0; p < N_WRITE_PORTS; p++) begin
                        if (p < n_used && port_addr[p] == addr) begin
                            clash = 1'b1;
                        end
                    end
                    if (!clash) begin
                        take = 1'b1;
                        for (int p = 0; p < N_WRITE_PORTS; p++) begin
                            if (p == n_used) begin
                                port_en[p]   = 1'b1;
                                port_addr[p] = addr;
                                port_data[p] = req.req_data[idx];
                            end
                        end
                        n_used = n_used + 1;
                    end
                end
                if (take) begin
                    grant[idx] = 1'b1;
                    if (!any_grant) begin
                        first_idx = idx;
                    end
                    any_grant = 1'b1;
                end
            end
        end
    end

    assign req.req_ready = grant;

    // Pointer moves past the first winner so it loses priority next time.
    assign nxt_ptr = (first_idx == RR_W'(N_REQ - 1)) ? '0
                                                    : first_idx + RR_W'(1);

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            rr_ptr  <= '0;
            wr_en   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= port_en;
            for (int p = 0; p < N_WRITE_PORTS; p++) begin
                if (port_en[p]) begin
                    wr_addr[p] <= port_addr[p];
                    wr_data[p] <= port_data[p];
                end
            end
            if (any_grant) begin
                rr_ptr <= nxt_ptr;
            end
        end
    end

endmodule

// File: doc/regfile_wr_arb.md
# regfile_wr_arb

Write-port arbiter and sequencer for the architectural/physical register file. It accepts writeback requests from `N_REQ` functional-unit requesters using a valid/ready handshake. Each cycle it grants up to `N_WRITE_PORTS` of them in round-robin order, never granting two requests to the same register in one cycle. Granted writes are registered and drive the register file's `wr_en`/`wr_addr`/`wr_data` ports one cycle later. Writes to register 0 are optionally absorbed without consuming a port.

## Interface
- `N_REQ`, 4, number of writeback requesters (≥2)
- `N_WRITE_PORTS`, 2, register-file write ports driven (1 ≤ `N_WRITE_PORTS` ≤ `N_REQ`)
- `ENTRY_WIDTH`, 32, data width
- `N_ENTRIES`, 32, register-file depth; `PTR_WIDTH` = $clog2(`N_ENTRIES`) (localparam)
- `DROP_ADDR0`, 1, when 1, address-0 requests are accepted and discarded

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_aH`  in  1  reset; asynchronous, active-high
- `hold`  in  1  when 1, no grants this cycle
- `req_valid`  in  [N_REQ]  request valid per requester
- `req_addr`  in  [N_REQ][PTR_WIDTH]  destination register
- `req_data`  in  [N_REQ][ENTRY_WIDTH]  write data
- `req_ready`  out  [N_REQ]  grant; handshake completes when `req_valid` & `req_ready`
- `wr_en`  out  [N_WRITE_PORTS]  registered write enables to the register file
- `wr_addr`  out  [N_WRITE_PORTS][PTR_WIDTH]  registered write addresses
- `wr_data`  out  [N_WRITE_PORTS][ENTRY_WIDTH]  registered write data

## Operation
- State: round-robin pointer `rr_ptr` ($clog2(N_REQ) bits), plus output registers `wr_en`, `wr_addr`, `wr_data`.
- Grant scan, combinational, each cycle with `hold`=0:
  - Visit requesters `rr_ptr`, `rr_ptr+1`, … mod `N_REQ`, each once.
  - A valid request is granted if a port is free and its address does not equal the address of a request already granted to a port this cycle.
  - If `DROP_ADDR0`=1 and `req_addr`=0, the request is always granted. It consumes no port and never causes a conflict.
- Port assignment: port-consuming grants take ports 0, 1, … in scan order. The register file's port-0 priority is therefore never exercised.
- `req_ready[i]` = `req_valid[i]` & granted. It is 0 when `hold`=1 or `rst_aH`=1. Requesters must not make `req_valid` depend on `req_ready`.
- Ungranted valid requests must hold `req_addr`/`req_data` stable until granted.
- Output register update at each edge:
  - Port p loaded with the p-th granted request: `wr_en[p]`=1, with its addr and data.
  - Unused ports: `wr_en[p]`=0; `wr_addr`/`wr_data` hold their previous values.
- Pointer update:
  - If at least one request (including a dropped address-0 request) was granted, `rr_ptr` ← (index of first granted requester + 1) mod `N_REQ`.
  - Otherwise `rr_ptr` is unchanged.
  - Guarantee: a continuously valid request is granted within `N_REQ` non-hold cycles.
- Same-cycle conflicts across cycles are not filtered. Two writes to the same address in consecutive cycles both occur, in grant order.

## Timing
- Reset, asynchronous, takes effect immediately: `rr_ptr`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0. `req_ready`=0 while `rst_aH`=1.
- First grants are possible in the first cycle after `rst_aH` deasserts.
- Latency:
  - Handshake in cycle k → `wr_en`/`wr_addr`/`wr_data` valid in cycle k+1.
  - The register file captures the write at the end of cycle k+1.
  - The value is readable from the register file in cycle k+2.
- `hold`: takes effect in the same cycle (no grants). Next cycle `wr_en`=0, and `rr_ptr` is unchanged.
- Reset mid-operation: writes already registered are lost; `wr_en` goes to 0 immediately.
- All requesters valid every cycle: exactly `min(N_WRITE_PORTS, non-conflicting valid)` grants per cycle.

## Test plan
- Reset with all `req_valid`=1 → `req_ready`=0 and `wr_en`=0 during reset. First cycle after reset: grants to req0 and req1, `rr_ptr`→1.
- All 4 requesters valid for 4 cycles, distinct addresses, never dropping `req_valid` → grant pairs (0,1),(1,2),(2,3),(3,0). Each `wr_*` appears on ports 0/1 one cycle later, in scan order.
- req0 and req1 both addr 5, req2 addr 7, `rr_ptr`=0 → grant req0 (port 0) and req2 (port 1); req1 stalls. Next cycle `rr_ptr`=1, and req1 is granted on port 0.
- `DROP_ADDR0`=1, req0 addr 0, req1 addr 3, req2 addr 4 → all three get `req_ready`=1. Next cycle `wr_en`=2'b11 with addrs 3 and 4; no write to addr 0.
- `hold`=1 for 2 cycles with req3 valid → `req_ready`=0, `wr_en`=0, `rr_ptr` unchanged. `hold`=0 → req3 granted the same cycle.
- Assert `rst_aH` mid-stream one cycle after a grant → `wr_en` drops to 0 asynchronously and `rr_ptr`=0.
